// File: rtl/alu_issue_scheduler_pkg.sv
// Shared RV32I types: ALU opcodes, ALU lane payload and reservation-station entry,
// plus the sizing constants of the ALU reservation station.
package rv32i_types;

   localparam int RS_TAG_W    = 4;
   localparam int ALU_RS_SIZE = 8;
   localparam int ALU_ISSUE_W = 2;

   typedef enum logic [3:0] {
      ALU_ADD  = 4'd0,
      ALU_SUB  = 4'd1,
      ALU_AND  = 4'd2,
      ALU_OR   = 4'd3,
      ALU_XOR  = 4'd4,
      ALU_SLL  = 4'd5,
      ALU_SRL  = 4'd6,
      ALU_SRA  = 4'd7,
      ALU_SLT  = 4'd8,
      ALU_SLTU = 4'd9
   } alu_ops;

   typedef struct packed {
      alu_ops                op;
      logic [RS_TAG_W-1:0]   tag;
      logic [31:0]           r1;
      logic [31:0]           r2;
   } rs_t;

   typedef struct packed {
      logic                  valid;
      alu_ops                op;
      logic [RS_TAG_W-1:0]   tag;
      logic [31:0]           r1;
      logic                  r1_vld;
      logic [31:0]           r2;
      logic                  r2_vld;
   } rs_entry_t;

endpackage

// File: rtl/alu_issue_scheduler_if.sv
// Dispatch, CDB snoop and ALU lane bundle of the ALU reservation station.
// The slave side is the scheduler; the master side is its environment.
interface alu_issue_scheduler_if
   import rv32i_types::*;
#(
   parameter int SIZE    = ALU_RS_SIZE,
   parameter int ISSUE_W = ALU_ISSUE_W,
   parameter int CDB_N   = 2,
   parameter int TAG_W   = RS_TAG_W
) ();

   logic                         flush;
   logic                         disp_valid;
   logic                         disp_ready;
   alu_ops                       disp_op;
   logic [TAG_W-1:0]             disp_tag;
   logic                         disp_r1_vld;
   logic [31:0]                  disp_r1;
   logic                         disp_r2_vld;
   logic [31:0]                  disp_r2;
   logic [CDB_N-1:0]             cdb_valid;
   logic [CDB_N*TAG_W-1:0]       cdb_tag;
   logic [CDB_N*32-1:0]          cdb_data;
   rs_t  [ISSUE_W-1:0]           alu_data;
   logic [ISSUE_W-1:0]           alu_ready;
   logic [$clog2(SIZE+1)-1:0]    occupancy;

   modport master (
      output flush, disp_valid, disp_op, disp_tag, disp_r1_vld, disp_r1,
             disp_r2_vld, disp_r2, cdb_valid, cdb_tag, cdb_data,
      input  disp_ready, alu_data, alu_ready, occupancy
   );

   modport slave (
      input  flush, disp_valid, disp_op, disp_tag, disp_r1_vld, disp_r1,
             disp_r2_vld, disp_r2, cdb_valid, cdb_tag, cdb_data,
      output disp_ready, alu_data, alu_ready, occupancy
   );

endinterface

// File: rtl/alu_issue_scheduler_rs_age_select.sv
// Oldest-first picker: grants up to ISSUE_W eligible entries, one per lane,
// repeatedly taking the entry with no older eligible peer and masking it out.
module rs_age_select #(
   parameter int SIZE    = 8,
   parameter int ISSUE_W = 2
) (
   input  logic [SIZE-1:0]               eligible,
   input  logic [SIZE-1:0][SIZE-1:0]     older,
   output logic [ISSUE_W-1:0][SIZE-1:0]  grant
);

   logic [SIZE-1:0] remaining;
   logic            taken;

   // older[i][j] means entry j is older than entry i
   always_comb begin
      remaining = eligible;
      taken     = 1'b0;
      grant     = '0;
      for (int k = 0; k < ISSUE_W; k++) begin
         taken = 1'b0;
         for (int i = 0; i < SIZE; i++) begin
            if (remaining[i] && ((older[i] & remaining) == '0) && !taken) begin
               grant[k][i] = 1'b1;
               taken       = 1'b1;
            end
         end
         remaining = remaining & ~grant[k];
      end
   end

endmodule

// File: rtl/alu_issue_scheduler.sv
// ALU reservation station: buffers dispatched ops, wakes operands from the CDB and
// issues up to ISSUE_W ready entries per cycle, oldest first, onto the ALU lanes.
module alu_issue_scheduler
   import rv32i_types::*;
#(
   parameter int SIZE    = ALU_RS_SIZE,
   parameter int ISSUE_W = ALU_ISSUE_W,
   parameter int CDB_N   = 2,
   parameter int TAG_W   = RS_TAG_W
) (
   input  logic               clk,
   input  logic               rst,
   alu_issue_scheduler_if.slave bus
);

   localparam int OCC_W = $clog2(SIZE + 1);
   localparam logic [OCC_W-1:0] SIZE_C = OCC_W'(SIZE);

   rs_entry_t                     ent_q   [SIZE];
   rs_entry_t                     ent_d   [SIZE];
   logic [SIZE-1:0][SIZE-1:0]     older_q;
   logic [SIZE-1:0][SIZE-1:0]     older_d;
   logic [SIZE-1:0]               valid_vec;
   logic [SIZE-1:0]               elig;
   logic [SIZE-1:0]               issued;
   logic [SIZE-1:0]               free_sel;
   logic [ISSUE_W-1:0][SIZE-1:0]  grant;
   logic [OCC_W-1:0]              occ;
   logic                          issue_en;
   logic                          accept;
   logic                          free_found;
   logic                          cdb_dup;
   rs_entry_t                     new_ent;
   rs_t                           lane_data;

   // A pending operand holds its producer tag in the low bits; a matching broadcast supplies the value
   function automatic logic [32:0] snoop(
      input logic                   vld,
      input logic [31:0]            val,
      input logic [CDB_N-1:0]       cv,
      input logic [CDB_N*TAG_W-1:0] ct,
      input logic [CDB_N*32-1:0]    cd
   );
      logic [32:0] res;
      res = {vld, val};
      if (!vld) begin
         for (int c = 0; c < CDB_N; c++) begin
            if (cv[c] && (ct[c*TAG_W +: TAG_W] == val[TAG_W-1:0])) begin
               res = {1'b1, cd[c*32 +: 32]};
            end
         end
      end
      return res;
   endfunction

   always_comb begin
      valid_vec = '0;
      elig      = '0;
      occ       = '0;
      for (int i = 0; i < SIZE; i++) begin
         valid_vec[i] = ent_q[i].valid;
         elig[i]      = ent_q[i].valid && ent_q[i].r1_vld && ent_q[i].r2_vld;
         occ          = occ + {{(OCC_W-1){1'b0}}, ent_q[i].valid};
      end
   end

   rs_age_select #(
      .SIZE    (SIZE),
      .ISSUE_W (ISSUE_W)
   ) u_select (
      .eligible (elig),
      .older    (older_q),
      .grant    (grant)
   );

   assign issue_en       = !rst && !bus.flush;
   assign bus.disp_ready = (occ < SIZE_C) && !bus.flush && !rst;
   assign bus.occupancy  = occ;
   assign accept         = bus.disp_valid && bus.disp_ready;

   always_comb begin
      issued        = '0;
      bus.alu_ready = '0;
      bus.alu_data  = '0;
      lane_data     = '0;
      for (int k = 0; k < ISSUE_W; k++) begin
         lane_data = '0;
         for (int i = 0; i < SIZE; i++) begin
            if (grant[k][i]) begin
               lane_data = '{op: ent_q[i].op, tag: ent_q[i].tag, r1: ent_q[i].r1, r2: ent_q[i].r2};
            end
         end
         if (issue_en) begin
            issued           = issued | grant[k];
            bus.alu_ready[k] = |grant[k];
            bus.alu_data[k]  = lane_data;
         end
      end
   end

   always_comb begin
      free_sel   = '0;
      free_found = 1'b0;
      for (int i = 0; i < SIZE; i++) begin
         if (!valid_vec[i] && !free_found) begin
            free_sel[i] = 1'b1;
            free_found  = 1'b1;
         end
      end
   end

   always_comb begin
      new_ent       = '0;
      new_ent.valid = 1'b1;
      new_ent.op    = bus.disp_op;
      new_ent.tag   = bus.disp_tag;
      {new_ent.r1_vld, new_ent.r1} = snoop(bus.disp_r1_vld, bus.disp_r1,
                                           bus.cdb_valid, bus.cdb_tag, bus.cdb_data);
      {new_ent.r2_vld, new_ent.r2} = snoop(bus.disp_r2_vld, bus.disp_r2,
                                           bus.cdb_valid, bus.cdb_tag, bus.cdb_data);
   end

   // Next state: wakeup, free issued slots, insert the dispatch as youngest, then flush overrides all
   always_comb begin
      ent_d   = ent_q;
      older_d = older_q;
      for (int i = 0; i < SIZE; i++) begin
         if (ent_q[i].valid) begin
            {ent_d[i].r1_vld, ent_d[i].r1} = snoop(ent_q[i].r1_vld, ent_q[i].r1,
                                                   bus.cdb_valid, bus.cdb_tag, bus.cdb_data);
            {ent_d[i].r2_vld, ent_d[i].r2} = snoop(ent_q[i].r2_vld, ent_q[i].r2,
                                                   bus.cdb_valid, bus.cdb_tag, bus.cdb_data);
         end
         if (issued[i]) begin
            ent_d[i].valid = 1'b0;
            for (int r = 0; r < SIZE; r++) begin
               older_d[r][i] = 1'b0;
            end
         end
      end
      if (accept) begin
         for (int i = 0; i < SIZE; i++) begin
            if (free_sel[i]) begin
               ent_d[i]   = new_ent;
               older_d[i] = valid_vec & ~issued;
            end
         end
      end
      if (bus.flush) begin
         for (int i = 0; i < SIZE; i++) begin
            ent_d[i].valid = 1'b0;
         end
         older_d = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < SIZE; i++) begin
            ent_q[i] <= '0;
         end
         older_q <= '0;
      end else begin
         ent_q   <= ent_d;
         older_q <= older_d;
      end
   end

   always_comb begin
      cdb_dup = 1'b0;
      for (int a = 0; a < CDB_N; a++) begin
         for (int b = a + 1; b < CDB_N; b++) begin
            if (bus.cdb_valid[a] && bus.cdb_valid[b] &&
                (bus.cdb_tag[a*TAG_W +: TAG_W] == bus.cdb_tag[b*TAG_W +: TAG_W])) begin
               cdb_dup = 1'b1;
            end
         end
      end
   end

   cdb_tags_unique: assert property (@(posedge clk) disable iff (rst) !cdb_dup);

endmodule

// File: tb/tb_alu_issue_scheduler.sv
// Bench for alu_issue_scheduler: a queue-in-age-order model predicts every output each
// cycle, and directed scenarios pin the model with hand-computed lane values.
module tb_alu_issue_scheduler;
   import rv32i_types::*;

   typedef struct {
      alu_ops      op;
      logic [3:0]  tag;
      logic [31:0] r1;
      bit          r1v;
      logic [31:0] r2;
      bit          r2v;
   } m_ent_t;

   typedef struct {
      bit          rst;
      bit          flush;
      bit          dv;
      alu_ops      op;
      logic [3:0]  tag;
      bit          r1v;
      logic [31:0] r1;
      bit          r2v;
      logic [31:0] r2;
      logic [1:0]  cv;
      logic [3:0]  ct0;
      logic [3:0]  ct1;
      logic [31:0] cd0;
      logic [31:0] cd1;
   } stim_t;

   logic   clk;
   logic   rst;
   int     checks;
   int     errors;
   bit     chk_on;
   m_ent_t mq[$];

   alu_issue_scheduler_if #(.SIZE(8), .ISSUE_W(2), .CDB_N(2), .TAG_W(4)) bus ();

   alu_issue_scheduler #(.SIZE(8), .ISSUE_W(2), .CDB_N(2), .TAG_W(4)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [95:0] act, input logic [95:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic bit cdbHit(input logic [3:0] t, output logic [31:0] v);
      v = '0;
      for (int c = 0; c < 2; c++) begin
         if (bus.cdb_valid[c] && bus.cdb_tag[c*4 +: 4] == t) begin
            v = bus.cdb_data[c*32 +: 32];
            return 1'b1;
         end
      end
      return 1'b0;
   endfunction

   function automatic m_ent_t wakeEntry(input m_ent_t e);
      logic [31:0] v;
      if (!e.r1v && cdbHit(e.r1[3:0], v)) begin
         e.r1  = v;
         e.r1v = 1'b1;
      end
      if (!e.r2v && cdbHit(e.r2[3:0], v)) begin
         e.r2  = v;
         e.r2v = 1'b1;
      end
      return e;
   endfunction

   // Model: mq holds live entries oldest first; the first two ready ones issue
   always @(posedge clk) begin : model_update
      int     n;
      int     pre;
      m_ent_t e;
      m_ent_t keep[$];
      if (rst || bus.flush) begin
         mq.delete();
      end else begin
         pre = mq.size();
         n   = 0;
         keep.delete();
         foreach (mq[i]) begin
            if (mq[i].r1v && mq[i].r2v && n < 2) n++;
            else keep.push_back(wakeEntry(mq[i]));
         end
         if (bus.disp_valid && pre < 8) begin
            e = '{op: bus.disp_op, tag: bus.disp_tag, r1: bus.disp_r1, r1v: bus.disp_r1_vld,
                  r2: bus.disp_r2, r2v: bus.disp_r2_vld};
            keep.push_back(wakeEntry(e));
         end
         mq = keep;
      end
   end

   always @(negedge clk) begin : compare
      logic [1:0]  er;
      logic [71:0] ed [2];
      int          k;
      if (chk_on) begin
         er = '0;
         ed[0] = '0;
         ed[1] = '0;
         k = 0;
         if (!rst && !bus.flush) begin
            foreach (mq[i]) begin
               if (mq[i].r1v && mq[i].r2v && k < 2) begin
                  er[k] = 1'b1;
                  ed[k] = {mq[i].op, mq[i].tag, mq[i].r1, mq[i].r2};
                  k++;
               end
            end
         end
         checkOutput("disp_ready", bus.disp_ready, (mq.size() < 8) && !rst && !bus.flush);
         checkOutput("occupancy", bus.occupancy, mq.size());
         checkOutput("alu_ready", bus.alu_ready, er);
         for (int l = 0; l < 2; l++) begin
            checkOutput($sformatf("lane%0d_data", l), bus.alu_data[l], ed[l]);
         end
      end
   end

   function automatic stim_t idle();
      stim_t s;
      s = '{rst: 1'b0, flush: 1'b0, dv: 1'b0, op: ALU_ADD, tag: '0, r1v: 1'b0, r1: '0,
            r2v: 1'b0, r2: '0, cv: '0, ct0: '0, ct1: '0, cd0: '0, cd1: '0};
      return s;
   endfunction

   function automatic stim_t disp(input alu_ops op, input logic [3:0] tag, input bit r1v,
                                  input logic [31:0] r1, input bit r2v, input logic [31:0] r2);
      stim_t s;
      s = idle();
      s.dv = 1'b1; s.op = op; s.tag = tag;
      s.r1v = r1v; s.r1 = r1; s.r2v = r2v; s.r2 = r2;
      return s;
   endfunction

   function automatic stim_t withCdb(input stim_t s, input int port, input logic [3:0] t,
                                     input logic [31:0] d);
      stim_t r;
      r = s;
      if (port == 0) begin r.cv[0] = 1'b1; r.ct0 = t; r.cd0 = d; end
      else           begin r.cv[1] = 1'b1; r.ct1 = t; r.cd1 = d; end
      return r;
   endfunction

   // Inputs change 1ns after the rising edge; callers inspect outputs at the following falling edge
   task automatic applyStimulus(input stim_t s);
      @(posedge clk);
      #1;
      rst             = s.rst;
      bus.flush       = s.flush;
      bus.disp_valid  = s.dv;
      bus.disp_op     = s.op;
      bus.disp_tag    = s.tag;
      bus.disp_r1_vld = s.r1v;
      bus.disp_r1     = s.r1;
      bus.disp_r2_vld = s.r2v;
      bus.disp_r2     = s.r2;
      bus.cdb_valid   = s.cv;
      bus.cdb_tag     = {s.ct1, s.ct0};
      bus.cdb_data    = {s.cd1, s.cd0};
      @(negedge clk);
   endtask

   initial begin : watchdog
      #100000;
      $display("[TB] FAIL watchdog: got timeout expected completion");
      $fatal(1, "[TB] simulation did not finish");
   end

   initial begin : stimulus
      stim_t s;
      checks = 0;
      errors = 0;
      chk_on = 1'b0;
      rst = 1'b1;
      bus.flush = 1'b0; bus.disp_valid = 1'b0; bus.disp_op = ALU_ADD; bus.disp_tag = '0;
      bus.disp_r1_vld = 1'b0; bus.disp_r1 = '0; bus.disp_r2_vld = 1'b0; bus.disp_r2 = '0;
      bus.cdb_valid = '0; bus.cdb_tag = '0; bus.cdb_data = '0;

      s = idle(); s.rst = 1'b1;
      applyStimulus(s);
      chk_on = 1'b1;
      applyStimulus(s);
      checkOutput("rst_disp_ready", bus.disp_ready, 0);
      checkOutput("rst_alu_ready", bus.alu_ready, 0);
      applyStimulus(idle());
      checkOutput("post_rst_disp_ready", bus.disp_ready, 1);
      checkOutput("post_rst_occ", bus.occupancy, 0);

      applyStimulus(disp(ALU_ADD, 4'd3, 1, 32'd5, 1, 32'd7));
      checkOutput("t1_not_yet", bus.alu_ready, 0);
      applyStimulus(idle());
      checkOutput("t1_ready", bus.alu_ready, 2'b01);
      checkOutput("t1_r1", bus.alu_data[0].r1, 32'd5);
      checkOutput("t1_r2", bus.alu_data[0].r2, 32'd7);
      checkOutput("t1_tag", bus.alu_data[0].tag, 4'd3);
      applyStimulus(idle());
      checkOutput("t1_occ_after", bus.occupancy, 0);

      applyStimulus(disp(ALU_SUB, 4'd2, 0, 32'd9, 1, 32'd1));
      applyStimulus(idle());
      checkOutput("t2_pending", bus.alu_ready, 0);
      applyStimulus(withCdb(idle(), 0, 4'd9, 32'h10));
      checkOutput("t2_no_bypass", bus.alu_ready, 0);
      applyStimulus(idle());
      checkOutput("t2_ready", bus.alu_ready, 2'b01);
      checkOutput("t2_r1", bus.alu_data[0].r1, 32'h10);
      checkOutput("t2_op", bus.alu_data[0].op, ALU_SUB);
      applyStimulus(idle());

      for (int t = 1; t <= 3; t++) begin
         applyStimulus(disp(ALU_AND, 4'(t), 0, 32'd10, 1, 32'(t)));
      end
      applyStimulus(withCdb(idle(), 0, 4'd10, 32'h20));
      checkOutput("t3_wait", bus.alu_ready, 0);
      applyStimulus(idle());
      checkOutput("t3_ready", bus.alu_ready, 2'b11);
      checkOutput("t3_lane0_tag", bus.alu_data[0].tag, 4'd1);
      checkOutput("t3_lane1_tag", bus.alu_data[1].tag, 4'd2);
      applyStimulus(idle());
      checkOutput("t3_third", bus.alu_ready, 2'b01);
      checkOutput("t3_third_tag", bus.alu_data[0].tag, 4'd3);
      applyStimulus(idle());

      for (int k = 0; k < 8; k++) begin
         applyStimulus(disp(ALU_OR, 4'(k), 0, 32'(k + 8), 1, 32'(k)));
      end
      applyStimulus(disp(ALU_XOR, 4'd9, 1, 32'd1, 1, 32'd1));
      checkOutput("t4_full_ready", bus.disp_ready, 0);
      checkOutput("t4_full_occ", bus.occupancy, 8);
      applyStimulus(withCdb(idle(), 0, 4'd10, 32'h55));
      checkOutput("t4_dropped_occ", bus.occupancy, 8);
      applyStimulus(idle());
      checkOutput("t4_wake_ready", bus.alu_ready, 2'b01);
      checkOutput("t4_wake_tag", bus.alu_data[0].tag, 4'd2);
      checkOutput("t4_wake_r1", bus.alu_data[0].r1, 32'h55);
      checkOutput("t4_issue_full", bus.disp_ready, 0);
      applyStimulus(disp(ALU_ADD, 4'd9, 0, 32'd15, 1, 32'h99));
      checkOutput("t4_reopen", bus.disp_ready, 1);
      checkOutput("t4_reopen_occ", bus.occupancy, 7);
      applyStimulus(withCdb(withCdb(idle(), 0, 4'd8, 32'h80), 1, 4'd15, 32'hF0));
      checkOutput("t4_refill_occ", bus.occupancy, 8);
      applyStimulus(idle());
      checkOutput("t4_age_lane0", bus.alu_data[0].tag, 4'd0);
      checkOutput("t4_age_lane1", bus.alu_data[1].tag, 4'd7);
      checkOutput("t4_age_r1", bus.alu_data[1].r1, 32'hF0);
      applyStimulus(idle());
      checkOutput("t4_young_tag", bus.alu_data[0].tag, 4'd9);
      checkOutput("t4_young_ready", bus.alu_ready, 2'b01);
      applyStimulus(idle());
      checkOutput("t6_occ5", bus.occupancy, 5);

      applyStimulus(disp(ALU_ADD, 4'd11, 1, 32'd1, 1, 32'd2));
      s = disp(ALU_ADD, 4'd12, 1, 32'd3, 1, 32'd4); s.flush = 1'b1;
      applyStimulus(s);
      checkOutput("t6_flush_alu", bus.alu_ready, 0);
      checkOutput("t6_flush_disp", bus.disp_ready, 0);
      applyStimulus(idle());
      checkOutput("t6_after_occ", bus.occupancy, 0);
      checkOutput("t6_after_alu", bus.alu_ready, 0);

      s = withCdb(disp(ALU_SLT, 4'd1, 0, 32'd6, 1, 32'd2), 1, 4'd6, 32'hAB);
      applyStimulus(s);
      applyStimulus(idle());
      checkOutput("t5_ready", bus.alu_ready, 2'b01);
      checkOutput("t5_r1", bus.alu_data[0].r1, 32'hAB);
      applyStimulus(idle());

      applyStimulus(disp(ALU_SRA, 4'd5, 0, 32'd12, 1, 32'd3));
      s = disp(ALU_ADD, 4'd6, 1, 32'd1, 1, 32'd1); s.rst = 1'b1; s.flush = 1'b1;
      applyStimulus(s);
      checkOutput("t6_rstflush_disp", bus.disp_ready, 0);
      checkOutput("t6_rstflush_alu", bus.alu_ready, 0);
      applyStimulus(idle());
      checkOutput("t6_rstflush_occ", bus.occupancy, 0);
      checkOutput("t6_rstflush_open", bus.disp_ready, 1);
      applyStimulus(idle());

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
